// File: rtl/mem_ref_pkg.sv
// Shared constants, FSM state type and address helper for the multi-port read-ref store.
package mem_ref_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  // Byte address to word index: drop the byte-offset bits, then wrap into the array depth.
  function automatic logic [31:0] word_index(input logic [63:0] addr, input int data_width,
                                             input int depth);
    logic [63:0] w;
    w = addr >> $clog2(data_width / 8);
    return 32'(w & 64'(depth - 1));
  endfunction

endpackage

// File: rtl/mem_ref_rd_pipe.sv
// Per-port read-data delay line of STAGES registers; STAGES=0 is a wire.
// dout holds its value on cycles without valid; rst flushes every stage synchronously.
module mem_ref_rd_pipe #(
  parameter int DW     = 32,
  parameter int STAGES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  output logic [DW-1:0] o_dat
);

  if (STAGES == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst};
    assign o_vld    = i_vld;
    assign o_dat    = i_dat;
  end else begin : g_reg
    logic [STAGES-1:0] r_vld;
    logic [DW-1:0]     r_dat [STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= '0;
        for (int s = 0; s < STAGES; s++) r_dat[s] <= '0;
      end else begin
        r_vld[0] <= i_vld;
        if (i_vld) r_dat[0] <= i_dat;
        for (int s = 1; s < STAGES; s++) begin
          r_vld[s] <= r_vld[s-1];
          if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
        end
      end
    end

    assign o_vld = r_vld[STAGES-1];
    assign o_dat = r_dat[STAGES-1];
  end

endmodule

// File: rtl/mem_read_ref_mp.sv
// Multi-port byte-enabled reference store with clear-after-reset sequencer.
// Read latency READ_LATENCY cycles; no backpressure, requests are ignored while busy.
module mem_read_ref_mp
  import mem_ref_pkg::*;
#(
  parameter int MEM_SIZE       = 4096,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PORTS      = 2,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              i_re,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_addr_r,
  input  logic [NUM_PORTS-1:0]              i_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_addr_w,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] i_be,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   i_din,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   o_dout,
  output logic [NUM_PORTS-1:0]              o_rvalid,
  output logic                              o_busy,
  output logic                              o_wr_collision
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = MEM_SIZE / NB;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_clr_idx, w_clr_idx_nxt;
  logic                  w_clr_we;
  logic                  w_ready;
  logic [NUM_PORTS-1:0]  w_rd_ok, w_wr_ok;
  logic [IW-1:0]         w_ridx [NUM_PORTS];
  logic [IW-1:0]         w_widx [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_rd_word [NUM_PORTS];
  logic                  w_coll;
  logic                  r_coll;
  logic [NUM_PORTS-1:0]  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_rd_dat [NUM_PORTS];

  assign w_ready = (r_state == ST_READY) && !rst;
  assign w_rd_ok = i_re & {NUM_PORTS{w_ready}};
  assign w_wr_ok = i_we & {NUM_PORTS{w_ready}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we      = !rst;
        w_clr_idx_nxt = r_clr_idx + IW'(1);
        if (r_clr_idx == IW'(DEPTH - 1)) begin
          w_state_nxt   = ST_READY;
          w_clr_idx_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // Any byte claimed by two or more enabled writers on the same word.
  always_comb begin
    w_coll = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int k = j + 1; k < NUM_PORTS; k++) begin
        if (w_wr_ok[j] && w_wr_ok[k] && (w_widx[j] == w_widx[k]) &&
            (|(i_be[j*NB +: NB] & i_be[k*NB +: NB])))
          w_coll = 1'b1;
      end
    end
  end

  // Write-first forwarding walks ports high to low so the lowest-index writer lands last.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_rd_word[i] = r_mem[w_ridx[i]];
      if (RDW_MODE == RDW_WRITE_FIRST) begin
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
          if (w_wr_ok[j] && (w_widx[j] == w_ridx[i])) begin
            for (int b = 0; b < NB; b++) begin
              if (i_be[j*NB + b])
                w_rd_word[i][b*8 +: 8] = i_din[j*DATA_WIDTH + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
        if (w_wr_ok[j]) begin
          for (int b = 0; b < NB; b++) begin
            if (i_be[j*NB + b])
              r_mem[w_widx[j]][b*8 +: 8] <= i_din[j*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld <= '0;
      r_coll   <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) r_rd_dat[i] <= '0;
    end else begin
      r_rd_vld <= w_rd_ok;
      r_coll   <= w_coll;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_rd_ok[i]) r_rd_dat[i] <= w_rd_word[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_ridx[g] = IW'(word_index(64'(i_addr_r[g*ADDR_WIDTH +: ADDR_WIDTH]), DATA_WIDTH, DEPTH));
    assign w_widx[g] = IW'(word_index(64'(i_addr_w[g*ADDR_WIDTH +: ADDR_WIDTH]), DATA_WIDTH, DEPTH));

    mem_ref_rd_pipe #(
      .DW    (DATA_WIDTH),
      .STAGES(READ_LATENCY - 1)
    ) u_rd_pipe (
      .clk  (clk),
      .rst  (rst),
      .i_vld(r_rd_vld[g]),
      .i_dat(r_rd_dat[g]),
      .o_vld(o_rvalid[g]),
      .o_dat(o_dout[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign o_busy         = rst || (r_state == ST_CLEAR);
  assign o_wr_collision = r_coll;

endmodule

// File: tb/tb_mem_read_ref_mp.sv
// Bench: a default instance (2 ports, latency 1, read-first) and a 4-port, latency 2,
// write-first instance share one stimulus stream; ports 0/1 drive both.
module tb_mem_read_ref_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   re, we;
  logic [127:0] ar, aw, din;
  logic [15:0]  be;

  logic [63:0]  dout0;
  logic [1:0]   rv0;
  logic         busy0, coll0;
  logic [127:0] dout1;
  logic [3:0]   rv1;
  logic         busy1, coll1;

  mem_read_ref_mp u_dut0 (
    .clk(clk), .rst(rst),
    .i_re(re[1:0]), .i_addr_r(ar[63:0]), .i_we(we[1:0]), .i_addr_w(aw[63:0]),
    .i_be(be[7:0]), .i_din(din[63:0]),
    .o_dout(dout0), .o_rvalid(rv0), .o_busy(busy0), .o_wr_collision(coll0)
  );

  mem_read_ref_mp #(.NUM_PORTS(4), .READ_LATENCY(2), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_re(re), .i_addr_r(ar), .i_we(we), .i_addr_w(aw),
    .i_be(be), .i_din(din),
    .o_dout(dout1), .o_rvalid(rv1), .o_busy(busy1), .o_wr_collision(coll1)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, idx, act, exp, $time);
  endtask

  // Reference model: byte-addressed memory, first writer claims a byte, reads queued by due cycle.
  typedef struct {
    int          due;
    logic [31:0] dat;
  } rq_t;

  rq_t         rq [2][4][$];
  logic [7:0]  mb [2][4096];
  int          clr_cnt [2];
  logic [31:0] last [2][4];
  logic        exp_rv [2][4];
  logic        exp_coll [2];
  int          ncyc = 0;
  int          m_np, m_lat, m_ba;
  logic [31:0] m_pre [4];
  int          m_own [int];
  rq_t         m_e;

  function automatic logic [31:0] rdw(input int d, input logic [31:0] a);
    int w;
    w = int'((a >> 2) % 1024);
    return {mb[d][w*4+3], mb[d][w*4+2], mb[d][w*4+1], mb[d][w*4]};
  endfunction

  always @(posedge clk) begin
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      m_np  = d ? 4 : 2;
      m_lat = d ? 2 : 1;
      exp_coll[d] = 1'b0;
      for (int p = 0; p < 4; p++) exp_rv[d][p] = 1'b0;
      if (rst) begin
        clr_cnt[d] = 1024;
        for (int p = 0; p < 4; p++) begin
          rq[d][p].delete();
          last[d][p] = '0;
        end
        for (int b = 0; b < 4096; b++) mb[d][b] = 8'h00;
      end else if (clr_cnt[d] > 0) begin
        clr_cnt[d]--;
      end else begin
        for (int p = 0; p < m_np; p++) m_pre[p] = rdw(d, ar[p*32 +: 32]);
        m_own.delete();
        for (int p = 0; p < m_np; p++) begin
          if (we[p]) begin
            for (int b = 0; b < 4; b++) begin
              if (be[p*4 + b]) begin
                m_ba = int'((aw[p*32 +: 32] >> 2) % 1024) * 4 + b;
                if (m_own.exists(m_ba)) exp_coll[d] = 1'b1;
                else begin
                  m_own[m_ba] = p;
                  mb[d][m_ba] = din[p*32 + b*8 +: 8];
                end
              end
            end
          end
        end
        for (int p = 0; p < m_np; p++) begin
          if (re[p]) begin
            m_e.due = ncyc + m_lat - 1;
            m_e.dat = d ? rdw(d, ar[p*32 +: 32]) : m_pre[p];
            rq[d][p].push_back(m_e);
          end
        end
        for (int p = 0; p < m_np; p++) begin
          if (rq[d][p].size() > 0 && rq[d][p][0].due == ncyc) begin
            exp_rv[d][p] = 1'b1;
            last[d][p]   = rq[d][p][0].dat;
            void'(rq[d][p].pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy0", 0, busy0, rst || clr_cnt[0] > 0);
      chk("m_busy1", 1, busy1, rst || clr_cnt[1] > 0);
      chk("m_coll0", 0, coll0, exp_coll[0]);
      chk("m_coll1", 1, coll1, exp_coll[1]);
      for (int p = 0; p < 2; p++) begin
        chk("m_rvalid0", p, rv0[p], exp_rv[0][p]);
        chk("m_dout0", p, dout0[p*32 +: 32], last[0][p]);
      end
      for (int p = 0; p < 4; p++) begin
        chk("m_rvalid1", p, rv1[p], exp_rv[1][p]);
        chk("m_dout1", p, dout1[p*32 +: 32], last[1][p]);
      end
    end
  end

  typedef struct packed {
    logic [1:0]       we;
    logic [1:0][31:0] aw;
    logic [1:0][31:0] din;
    logic [1:0][3:0]  be;
    logic [1:0]       re;
    logic [1:0][31:0] ar;
    logic [1:0]       ev;
    logic [1:0][31:0] ed;
    logic             ec;
  } vec_t;

  localparam int NV = 16;
  vec_t tv [NV];

  function automatic vec_t mk(input logic [1:0] w, input logic [31:0] aw0, d0, input logic [3:0] b0,
                              input logic [31:0] aw1, d1, input logic [3:0] b1,
                              input logic [1:0] r, input logic [31:0] ar0, ar1,
                              input logic [1:0] ev, input logic [31:0] e0, e1, input logic ec);
    vec_t v;
    v.we = w;   v.aw[0] = aw0; v.din[0] = d0; v.be[0] = b0;
    v.aw[1] = aw1; v.din[1] = d1; v.be[1] = b1;
    v.re = r;   v.ar[0] = ar0; v.ar[1] = ar1;
    v.ev = ev;  v.ed[0] = e0;  v.ed[1] = e1;  v.ec = ec;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    re = '0; we = '0; be = '0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
  endfunction

  int cnt;
  int first [4];
  int lastk [4];
  int hits [4];

  initial begin
    rst = 1'b1; re = '0; we = '0; ar = '0; aw = '0; din = '0; be = '0;

    tv[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 32'h000, 32'h7FC, 2'b11, 32'h0, 32'h0, 0);
    tv[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 32'hFFC, 32'h0, 2'b01, 32'h0, 32'h0, 0);
    tv[2]  = mk(2'b01, 32'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    tv[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 32'h010, 2'b10, 0, 32'hDEADBEEF, 0);
    tv[4]  = mk(2'b01, 32'h020, 32'h11223344, 4'hF, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    tv[5]  = mk(2'b11, 32'h020, 32'hAAAAAAAA, 4'h3, 32'h020, 32'hBBBBBBBB, 4'h6,
                2'b00, 0, 0, 2'b00, 0, 0, 1);
    tv[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 32'h020, 2'b10, 0, 32'h11BBAAAA, 0);
    tv[7]  = mk(2'b11, 32'h020, 32'hAAAAAAAA, 4'h3, 32'h020, 32'hBBBBBBBB, 4'hC,
                2'b00, 0, 0, 2'b00, 0, 0, 0);
    tv[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 32'h020, 0, 2'b01, 32'hBBBBAAAA, 0, 0);
    tv[9]  = mk(2'b01, 32'h040, 32'h12345678, 4'hF, 0, 0, 0, 2'b10, 0, 32'h040, 2'b10, 0, 32'h0, 0);
    tv[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 32'h040, 2'b10, 0, 32'h12345678, 0);
    tv[11] = mk(2'b01, 32'h1004, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    tv[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 32'h004, 32'h1007, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    tv[13] = mk(2'b10, 0, 0, 0, 32'h030, 32'h55667788, 4'h0, 2'b01, 32'h030, 0, 2'b01, 32'h0, 0, 0);
    tv[14] = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 32'h030, 0, 2'b01, 32'h0, 0, 0);
    tv[15] = mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);

    step();
    chk_en = 1'b1;
    step();
    step();
    chk("rst_busy", 0, busy0, 1'b1);
    chk("rst_rvalid", 0, {30'b0, rv0}, 32'h0);
    chk("rst_dout", 0, dout0[31:0], 32'h0);
    chk("rst_coll", 0, coll0, 1'b0);
    rst = 1'b0;

    cnt = 0;
    while (busy0 === 1'b1 && cnt < 2000) begin
      step();
      cnt++;
    end
    chk("busy_len", 0, cnt, 1024);

    for (int i = 0; i < NV; i++) begin
      we = 4'(tv[i].we); re = 4'(tv[i].re);
      aw = 128'(tv[i].aw); ar = 128'(tv[i].ar); din = 128'(tv[i].din); be = 16'(tv[i].be);
      step();
      for (int p = 0; p < 2; p++) begin
        chk("tv_rvalid", i, rv0[p], tv[i].ev[p]);
        if (tv[i].ev[p]) chk("tv_dout", i, dout0[p*32 +: 32], tv[i].ed[p]);
      end
      chk("tv_coll", i, coll0, tv[i].ec);
    end
    idle();

    for (int k = 0; k < 800; k++) begin
      re = 4'($urandom);
      we = 4'($urandom & $urandom);
      be = 16'($urandom);
      for (int p = 0; p < 4; p++) begin
        ar[p*32 +: 32]  = rnd_addr();
        aw[p*32 +: 32]  = rnd_addr();
        din[p*32 +: 32] = $urandom;
      end
      step();
    end
    idle();
    step();
    step();

    // Write-first on the 4-port instance: port 3 reads the word port 2 writes.
    we = 4'b0100; aw[95:64] = 32'h080; din[95:64] = 32'h9ABCDEF0; be = 16'h0F00;
    re = 4'b1000; ar[127:96] = 32'h080;
    step();
    idle();
    chk("rdw1_early", 3, rv1[3], 1'b0);
    step();
    chk("rdw1_rvalid", 3, rv1[3], 1'b1);
    chk("rdw1_dout", 3, dout1[127:96], 32'h9ABCDEF0);
    step();

    for (int p = 0; p < 4; p++) begin
      first[p] = -1; lastk[p] = -1; hits[p] = 0;
    end
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        re = 4'hF;
        for (int p = 0; p < 4; p++) ar[p*32 +: 32] = 32'h100 + 32'((p*8 + k) * 4);
      end else re = '0;
      step();
      for (int p = 0; p < 4; p++) begin
        if (rv1[p]) begin
          hits[p]++;
          lastk[p] = k;
          if (first[p] < 0) first[p] = k;
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      chk("burst_hits", p, hits[p], 8);
      chk("burst_first", p, first[p], 1);
      chk("burst_last", p, lastk[p], 8);
    end

    re = 4'hF;
    step();
    re = '0;
    rst = 1'b1;
    step();
    chk("flush_rvalid1", 0, {28'b0, rv1}, 32'h0);
    chk("flush_rvalid0", 0, {30'b0, rv0}, 32'h0);
    chk("flush_dout1", 0, dout1[31:0], 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_quiet", k, {28'b0, rv1}, 32'h0);
    end
    repeat (497) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    while (busy1 === 1'b1 && cnt < 2000) begin
      step();
      cnt++;
    end
    chk("restart_busy_len", 0, cnt, 1024);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_read_ref_mp.md
Name: mem_read_ref_mp

Overview:
Parametrised multi-port reference-sequence memory for the DNA datapath. It is the next generation of the two-port read-ref store, generalised to NUM_PORTS independent channels. Each channel has its own read and write addresses, byte-enabled writes, configurable read latency and a read-valid flag. Adds deterministic write-collision resolution, a selectable read-during-write mode, and a reset-time clear sequencer with a busy flag. Sits between the DMA/loader and the alignment engines.

Parameters:
MEM_SIZE, 4096, memory size in bytes; MEM_SIZE/(DATA_WIDTH/8) must be a power of 2.
ADDR_WIDTH, 32, byte-address width per port.
DATA_WIDTH, 32, word width; multiple of 8.
NUM_PORTS, 2, number of channels, 1..4.
READ_LATENCY, 1, cycles from re to rvalid; 1 or 2.
RDW_MODE, 0, same-word read+write in one cycle: 0 = old data (read-first), 1 = new data (write-first).
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents untouched.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
re  in  NUM_PORTS  per-port read request
addr_r  in  NUM_PORTS*ADDR_WIDTH  per-port read byte address, port i at slice i
we  in  NUM_PORTS  per-port write request
addr_w  in  NUM_PORTS*ADDR_WIDTH  per-port write byte address
be  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, bit 0 = bits 7:0
din  in  NUM_PORTS*DATA_WIDTH  per-port write data
dout  out  NUM_PORTS*DATA_WIDTH  per-port read data
rvalid  out  NUM_PORTS  per-port read-data valid pulse
busy  out  1  clear in progress; re/we ignored
wr_collision  out  1  one-cycle pulse: two or more ports wrote the same byte

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. Both are fixed.
- DEPTH = MEM_SIZE/(DATA_WIDTH/8). Word index = byte address >> log2(DATA_WIDTH/8), then taken modulo DEPTH (upper bits dropped, so addresses wrap). The low byte-offset bits are ignored.
- Reset: rst=1 in a cycle means that at the next edge dout=0, rvalid=0, wr_collision=0 and the read pipeline is flushed (in-flight reads are discarded, never delivered). busy=1 while rst is high.
- FSM states are CLEAR and READY.
  - Leaving reset goes to CLEAR with clr_idx=0 if CLEAR_ON_RESET=1, otherwise to READY.
  - In CLEAR, word[clr_idx] is written to 0 and clr_idx increments once per cycle. After clr_idx=DEPTH-1 the FSM moves to READY, so CLEAR takes DEPTH cycles exactly.
  - busy=1 in CLEAR and drops on the first READY cycle. re/we/be are ignored in CLEAR and no rvalid is produced.
  - If rst is asserted mid-CLEAR, the sequence restarts from index 0.
- Reads in READY:
  - re[i] samples word[addr_r[i]].
  - READ_LATENCY=1: dout[i] and rvalid[i] update at the next edge.
  - READ_LATENCY=2: one extra register stage follows.
  - One read per port per cycle, fully pipelined with no bubbles.
  - dout[i] holds its last value when rvalid[i]=0.
- Writes in READY:
  - we[i] writes the bytes of din[i] where be[i]=1. be=0 is a no-op.
  - Writes are visible to any read issued in a later cycle.
- Collisions: when several ports write the same word in one cycle, the resolution is per byte, and the lowest-index port with that byte enabled wins. wr_collision pulses at the next edge if any byte had two or more writers. Overlapping words with disjoint byte enables is not a collision.
- Read-during-write, same word, same cycle, any port pair:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the post-resolution merged word, i.e. bytes forwarded from the winning writers and the remaining bytes from memory.
- Read with we=0 on all ports does not change memory. Reading an address never written since clear returns 0 when CLEAR_ON_RESET=1, and an undefined value otherwise.

Decomposition:
- Package mem_ref_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants
  - the state enum {ST_CLEAR, ST_READY}
  - the function word_index(addr, DATA_WIDTH, DEPTH)
- Sub-module mem_ref_rd_pipe is the per-port delay line for dout/rvalid with depth READ_LATENCY-1 and synchronous flush on rst. It is instantiated NUM_PORTS times.
- The top level holds the array, FSM, collision merge and RDW mux.

Test Plan:
- Defaults, rst high 3 cycles then low -> busy=1 for exactly 1024 cycles after rst deasserts, then 0. Reads of byte addr 0x000, 0x7FC and 0xFFC return 0 with rvalid one cycle after re.
- Port0 writes 0xDEADBEEF to 0x010 with be=0xF, then port1 reads 0x010 next cycle -> dout1=0xDEADBEEF one cycle later, rvalid1 a single pulse.
- Word 0x020 = 0x11223344; port0 be=0x3 din=0xAAAAAAAA and port1 be=0x6 din=0xBBBBBBBB, same cycle to 0x020 -> word=0x11BBAAAA and wr_collision=1 for one cycle. Repeat with be 0x3/0xC -> word=0xBBBBAAAA, no collision.
- Word 0x040 = 0x0; port0 writes 0x12345678 to 0x040 while port1 reads 0x040 in the same cycle -> RDW_MODE=0 returns 0x00000000, RDW_MODE=1 returns 0x12345678.
- READ_LATENCY=2, NUM_PORTS=4, back-to-back reads on all ports for 8 cycles -> each rvalid high for 8 consecutive cycles starting 2 cycles after the first re, with correct data in order. rst asserted with reads in flight -> no rvalid afterwards.
- Address wrap: write 0xCAFEF00D to byte addr 0x1004 -> a read of 0x004 returns 0xCAFEF00D. rst asserted at clr_idx=500 -> busy stays high for a further 1024 cycles after rst deasserts.
